// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line. A two-flop synchronizer feeds a
// mid-bit sampling FSM with false-start rejection, framing-error flag and break hold-off.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1302
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    s_IDLE       = 3'd0,
    s_START      = 3'd1,
    s_DATA       = 3'd2,
    s_STOP       = 3'd3,
    s_CLEANUP    = 3'd4,
    s_BREAK_WAIT = 3'd5
  } state_t;

  // r_SM_Main is the observable FSM state for assertions and debug probes.
  state_t      r_SM_Main;
  logic        r_Rx_Meta;
  logic        r_Rx;
  logic [15:0] r_Clock_Count;
  logic [2:0]  r_Bit_Index;
  logic [7:0]  r_Shift;

  // Both stages reset high so a reset never looks like a start bit.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Rx_Meta <= 1'b1;
      r_Rx      <= 1'b1;
    end else begin
      r_Rx_Meta <= i_Rx_Serial;
      r_Rx      <= r_Rx_Meta;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_SM_Main      <= s_IDLE;
      r_Clock_Count  <= 16'd0;
      r_Bit_Index    <= 3'd0;
      r_Shift        <= 8'h00;
      o_Rx_DV        <= 1'b0;
      o_Rx_Byte      <= 8'h00;
      o_Rx_Active    <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      case (r_SM_Main)
        s_IDLE: begin
          r_Clock_Count <= 16'd0;
          r_Bit_Index   <= 3'd0;
          if (!r_Rx) begin
            r_SM_Main   <= s_START;
            o_Rx_Active <= 1'b1;
          end
        end

        // Re-check the line at the middle of the start bit to reject glitches.
        s_START: begin
          if (r_Clock_Count == HALF) begin
            r_Clock_Count <= 16'd0;
            if (!r_Rx) begin
              r_SM_Main <= s_DATA;
            end else begin
              r_SM_Main   <= s_IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            r_Clock_Count <= r_Clock_Count + 16'd1;
          end
        end

        s_DATA: begin
          if (r_Clock_Count < LAST) begin
            r_Clock_Count <= r_Clock_Count + 16'd1;
          end else begin
            r_Clock_Count          <= 16'd0;
            r_Shift[r_Bit_Index]   <= r_Rx;
            if (r_Bit_Index == 3'd7) begin
              r_Bit_Index <= 3'd0;
              r_SM_Main   <= s_STOP;
            end else begin
              r_Bit_Index <= r_Bit_Index + 3'd1;
            end
          end
        end

        s_STOP: begin
          if (r_Clock_Count < LAST) begin
            r_Clock_Count <= r_Clock_Count + 16'd1;
          end else begin
            r_Clock_Count <= 16'd0;
            if (r_Rx) begin
              o_Rx_Byte <= r_Shift;
              o_Rx_DV   <= 1'b1;
              r_SM_Main <= s_CLEANUP;
            end else begin
              o_Rx_Frame_Err <= 1'b1;
              r_SM_Main      <= s_BREAK_WAIT;
            end
          end
        end

        s_CLEANUP: begin
          o_Rx_Active <= 1'b0;
          r_SM_Main   <= s_IDLE;
        end

        // A held-low line must release before another start can be accepted.
        s_BREAK_WAIT: begin
          if (r_Rx) begin
            o_Rx_Active <= 1'b0;
            r_SM_Main   <= s_IDLE;
          end
        end

        default: begin
          o_Rx_Active <= 1'b0;
          r_SM_Main   <= s_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: drives serial frames and compares received bytes and
// framing errors against a sample-point model evaluated over the recorded line trace.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;

  logic       clk = 1'b0;
  logic       i_Reset;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Rx_Frame_Err;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Reset        (i_Reset),
    .i_Rx_Serial    (i_Rx_Serial),
    .o_Rx_DV        (o_Rx_DV),
    .o_Rx_Byte      (o_Rx_Byte),
    .o_Rx_Active    (o_Rx_Active),
    .o_Rx_Frame_Err (o_Rx_Frame_Err)
  );

  int checks = 0;
  int failures = 0;

  int         cyc = 0;
  logic       rst_q = 1'b0;
  logic       mon_en = 1'b0;
  bit         trace[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         dv_cyc_q[$];
  int         exp_fe = 0;
  int         obs_fe = 0;
  int         viol = 0;
  int         base_fe = 0;
  int         base_viol = 0;
  int         act_run = 0;
  int         last_run = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] prev_good = 8'h00;
  logic [7:0] fe_byte = 8'h00;
  logic [7:0] prev_byte = 8'h00;
  logic       prev_dv = 1'b0;
  logic       prev_fe = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line recorder: trace[n] is the serial value captured by the first synchronizer flop.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= i_Reset;
    if (i_Reset) trace.delete();
    else trace.push_back(i_Rx_Serial);
  end

  always @(negedge clk) begin
    if (rst_q) begin
      check_eq("rst_dv", o_Rx_DV, 0);
      check_eq("rst_byte", o_Rx_Byte, 0);
      check_eq("rst_active", o_Rx_Active, 0);
      check_eq("rst_fe", o_Rx_Frame_Err, 0);
    end else if (mon_en) begin
      if (o_Rx_DV) begin
        obs_q.push_back(o_Rx_Byte);
        dv_cyc_q.push_back(cyc);
      end
      if (o_Rx_Frame_Err) begin
        obs_fe  <= obs_fe + 1;
        fe_byte <= o_Rx_Byte;
      end
      viol <= viol + int'(o_Rx_DV && o_Rx_Frame_Err) + int'(o_Rx_DV && prev_dv)
                   + int'(o_Rx_Frame_Err && prev_fe) + int'(!o_Rx_DV && (o_Rx_Byte != prev_byte));
    end
    prev_dv   <= o_Rx_DV;
    prev_fe   <= o_Rx_Frame_Err;
    prev_byte <= o_Rx_Byte;
    if (o_Rx_Active) act_run <= act_run + 1;
    else if (act_run > 0) begin
      last_run <= act_run;
      act_run  <= 0;
    end
  end

  // The receiver sees trace[i] two clocks after it is captured; a start found at
  // index s is confirmed at s+HALF+1 and data bit j is taken at s+HALF+1+CPB*(j+1).
  task automatic run_model();
    int n;
    int i;
    int stop_idx;
    int k;
    logic [7:0] b;
    n = trace.size();
    i = 0;
    exp_q.delete();
    exp_fe = 0;
    while (i < n) begin
      if (trace[i]) begin
        i++;
      end else if (i + HALF + 1 >= n) begin
        i = n;
      end else if (trace[i + HALF + 1]) begin
        i = i + HALF + 2;
      end else begin
        stop_idx = i + HALF + 1 + 9 * CPB;
        if (stop_idx >= n) begin
          i = n;
        end else begin
          for (int j = 0; j < 8; j++) b[j] = trace[i + HALF + 1 + CPB * (j + 1)];
          if (trace[stop_idx]) begin
            exp_q.push_back(b);
            last_good = b;
            i = stop_idx + 2;
          end else begin
            exp_fe++;
            k = stop_idx + 1;
            while (k < n && !trace[k]) k++;
            i = k + 1;
          end
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    i_Rx_Serial = 1'b1;
    tick(n);
  endtask

  // rst_bit >= 0 pulses i_Reset for one clock in the middle of that serial bit.
  task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop, input int rst_bit);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      i_Rx_Serial = bits[k];
      for (int c = 0; c < cpb; c++) begin
        i_Reset = (k == rst_bit) && (c == cpb / 2);
        tick(1);
      end
    end
    i_Reset = 1'b0;
  endtask

  task automatic new_scenario();
    trace.delete();
    obs_q.delete();
    dv_cyc_q.delete();
    base_fe   = obs_fe;
    base_viol = viol;
    prev_good = last_good;
  endtask

  task automatic end_scenario(input string tag);
    idle(40);
    run_model();
    check_eq({tag, "_ndv"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      check_eq({tag, "_byte"}, obs_q[k], exp_q[k]);
    check_eq({tag, "_nfe"}, obs_fe - base_fe, exp_fe);
    check_eq({tag, "_proto"}, viol - base_viol, 0);
    check_eq({tag, "_idle"}, o_Rx_Active, 0);
  endtask

  initial begin
    int start;
    int lat;
    logic [7:0] b;
    logic stop;

    i_Reset     = 1'b1;
    i_Rx_Serial = 1'b1;
    tick(3);
    i_Reset = 1'b0;
    mon_en  = 1'b1;
    idle(10);

    new_scenario();
    start = cyc;
    send_frame(8'hA5, CPB, 1'b1, -1);
    end_scenario("a5");
    lat = (dv_cyc_q.size() > 0) ? dv_cyc_q[0] - start : 0;
    check_eq("a5_latency", (lat >= 153 && lat <= 155), 1);
    check_eq("a5_value", o_Rx_Byte, 8'hA5);

    new_scenario();
    i_Rx_Serial = 1'b0;
    tick(4);
    idle(30);
    check_eq("glitch_active_len", last_run, HALF + 1);
    check_eq("glitch_ndv", obs_q.size(), 0);
    check_eq("glitch_nfe", obs_fe - base_fe, 0);
    send_frame(8'h3C, CPB, 1'b1, -1);
    end_scenario("glitch");
    check_eq("glitch_value", o_Rx_Byte, 8'h3C);

    new_scenario();
    send_frame(8'h5A, CPB, 1'b0, -1);
    tick(200);
    check_eq("brk_ndv", obs_q.size(), 0);
    check_eq("brk_nfe", obs_fe - base_fe, 1);
    check_eq("brk_hold", fe_byte, prev_good);
    check_eq("brk_active", o_Rx_Active, 1);
    idle(20);
    send_frame(8'h81, CPB, 1'b1, -1);
    end_scenario("brk");
    check_eq("brk_value", o_Rx_Byte, 8'h81);

    new_scenario();
    send_frame(8'h00, CPB, 1'b1, -1);
    send_frame(8'hFF, CPB, 1'b1, -1);
    send_frame(8'h55, CPB, 1'b1, -1);
    end_scenario("b2b");
    check_eq("b2b_count", obs_q.size(), 3);
    check_eq("b2b_value", o_Rx_Byte, 8'h55);

    new_scenario();
    b = {4'hF, 4'($urandom_range(0, 15))};
    send_frame(b, CPB, 1'b1, 5);
    idle(32);
    send_frame(8'hC3, CPB, 1'b1, -1);
    end_scenario("rst");
    check_eq("rst_value", o_Rx_Byte, 8'hC3);

    // At 15 clk/bit the late samples drift into the following bit, so the
    // expected byte comes from the sample-point model rather than the sent byte.
    new_scenario();
    send_frame(8'h96, 15, 1'b1, -1);
    end_scenario("tol15");

    new_scenario();
    send_frame(8'h96, 17, 1'b1, -1);
    end_scenario("tol17");
    check_eq("tol17_value", o_Rx_Byte, 8'h96);

    new_scenario();
    for (int f = 0; f < 12; f++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      send_frame(b, CPB, stop, -1);
      if (!stop) tick($urandom_range(0, 40));
      idle($urandom_range(0, 20));
    end
    end_scenario("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
